y_mem_stage: RTL
================

Y_MEM_STAGE -- requirements
Module: y_mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of cycles the block waits for mem_ack before aborting an access.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  an EX result is presented this cycle.
REQ-005 z  input  32  ALU result from EX; used as the memory address for loads and stores.
REQ-006 rd2  input  32  store data from ID.
REQ-007 MemRead, MemWrite, RegWrite  input  1 each  control bits for the presented instruction.
REQ-008 stall  output  1  upstream must hold PC, ins and all EX inputs while this is high.
REQ-009 mem_req, mem_we  output  1 each  memory request and write enable; both registered.
REQ-010 mem_addr, mem_wdata  output  32 each  registered address and write data.
REQ-011 mem_rdata  input  32  read data; valid in the cycle mem_ack is high.
REQ-012 mem_ack  input  1  memory completion strobe; single-cycle pulse.
REQ-013 wb_valid  output  1  single-cycle pulse: writeback data is ready.
REQ-014 wb_we  output  1  register-file write enable, qualified by wb_valid.
REQ-015 wb_data  output  32  value feeding the register-file wd input.
REQ-016 err  output  1  single-cycle pulse: access fault (misaligned, illegal, or timeout).

Function
REQ-017 FSM states: IDLE and WAIT; the state SHALL be IDLE after reset.
REQ-018 Non-memory instruction (in_valid=1 in IDLE, MemRead=MemWrite=0): on the next cycle, wb_valid=1, wb_data=z, wb_we=RegWrite. Latency is 1 cycle and the FSM stays in IDLE.
REQ-019 Load or store in IDLE with z[1:0]=00 and exactly one of MemRead/MemWrite set:
- Capture mem_addr=z, mem_wdata=rd2, mem_we=MemWrite and RegWrite.
- Assert mem_req=1 on the next cycle and enter WAIT.
REQ-020 Misaligned access (z[1:0]!=00), or MemRead=MemWrite=1, in IDLE: err=1 and wb_valid=0 on the next cycle; no mem_req is issued.
REQ-021 stall=1 exactly while the state is WAIT (combinational from state); in_valid is ignored during WAIT.
REQ-022 mem_req, mem_we, mem_addr and mem_wdata SHALL remain stable throughout WAIT.
REQ-023 mem_ack sampled high in WAIT: the next cycle has mem_req=0, state IDLE and wb_valid=1.
- Load: wb_data=mem_rdata as sampled with ack; wb_we=captured RegWrite.
- Store: wb_data=captured address; wb_we=0.
REQ-024 Timeout counter: 4-bit minimum, cleared on entry to WAIT, increments once per WAIT cycle without ack.
REQ-025 When the counter reaches TIMEOUT: next cycle has mem_req=0, err=1, wb_valid=0 and state IDLE.
REQ-026 mem_ack arriving in the same cycle the counter reaches TIMEOUT: the ack wins and err stays 0.
REQ-027 mem_ack sampled in IDLE SHALL be ignored.
REQ-028 wb_valid and err SHALL never both be 1 in the same cycle; each is high for exactly one cycle per instruction.
REQ-029 A new in_valid accepted in IDLE in the cycle immediately after a completion SHALL be processed normally, giving back-to-back throughput.

Reset
REQ-030 rst_n=0 SHALL asynchronously force:
- state=IDLE and counter=0;
- mem_req, mem_we, wb_valid, wb_we and err to 0;
- mem_addr, mem_wdata and wb_data to 0.
REQ-031 Reset asserted during WAIT SHALL abort the access immediately; no wb_valid or err pulse follows the reset release.

Structure
REQ-032 A shared package holds the state enum (IDLE, WAIT), the default TIMEOUT, and the RISC-V opcode constants 7'h03, 7'h23, 7'h33, 7'h13, 7'h63 and 7'h6F used by the datapath control.
REQ-033 The timeout counter is one natural sub-module, y_timeout_ctr, with ports clk, rst_n, clr, en and expired.

Verification
REQ-034 Test 1: add result with z=32'h5 and RegWrite=1. Required: wb_valid=1 one cycle later, wb_data=5, wb_we=1, stall never 1.
REQ-035 Test 2: load with z=32'h28 and an ack 3 cycles after mem_req with mem_rdata=32'h1234. Required: stall high for 3 cycles, then wb_data=32'h1234 and wb_we=1.
REQ-036 Test 3: store with z=32'h2C and rd2=32'hAA, ack after 1 cycle. Required: mem_we=1, mem_wdata=32'hAA, mem_addr=32'h2C; then wb_valid=1 with wb_we=0.
REQ-037 Test 4: load with z=32'h2A. Required: err=1 next cycle, and mem_req stays 0.
REQ-038 Test 5: load with no ack, TIMEOUT=15. Required: err=1 after 15 WAIT cycles and mem_req dropped. Repeat with the ack on cycle 15: required wb_valid=1 and err=0.
REQ-039 Test 6: rst_n pulsed low during WAIT. Required: all outputs 0 immediately, and no wb_valid or err pulse after release.

Source files
------------

// File: rtl/y_mem_stage_pkg.sv
// Shared definitions for the memory stage.
// - Holds the FSM state type and the datapath width.
// - Holds the default ack timeout.
// - Holds the RISC-V major opcodes used by the datapath control.
package y_mem_stage_pkg;

  localparam int DATA_W          = 32;
  localparam int DEFAULT_TIMEOUT = 15;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_ITYPE  = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/y_mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
// - master drives mem_req, mem_we, mem_addr and mem_wdata.
// - master receives mem_rdata and mem_ack.
// - mem_rdata is valid in the cycle mem_ack pulses.
interface y_mem_stage_if;
  import y_mem_stage_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/y_timeout_ctr.sv
// Ack timeout counter for the memory stage.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : restart the count at zero, used on entry to WAIT
//   en         : one WAIT cycle passed without an ack
//   expired    : this enabled cycle is the TIMEOUT-th without an ack
module y_timeout_ctr
  import y_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [CW-1:0] cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (clr) begin
      cnt_p1 <= '0;
    end else if (en) begin
      cnt_p1 <= cnt_p1 + CW'(1);
    end
  end

  // The count holds the number of ack-less WAIT cycles already seen. The
  // increment in this cycle would make it reach TIMEOUT, so the abort
  // decision is taken now and appears on the outputs one cycle later.
  assign expired = en && (cnt_p1 == CW'(TIMEOUT - 1));

endmodule

// File: rtl/y_mem_stage.sv
// MEM pipeline stage: issues loads/stores on the memory bus and produces a
// single writeback or error pulse per instruction.
// Ports:
//   clk, rst_n                  : clock and asynchronous active-low reset
//   in_valid, z, rd2            : EX result (address / ALU value) and store data
//   MemRead, MemWrite, RegWrite : control bits of the presented instruction
//   stall                       : upstream must hold while the access is outstanding
//   mem                         : memory bus (master side)
//   wb_valid, wb_we, wb_data    : writeback pulse, reg-file enable and data
//   err                         : fault pulse (misaligned, illegal or timeout)
module y_mem_stage
  import y_mem_stage_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] z,
  input  logic [DATA_W-1:0] rd2,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  output logic              stall,
  y_mem_stage_if.master     mem,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  state_t            state_p1, state_d;
  logic              req_p1, req_d;
  logic              we_p1, we_d;
  logic [DATA_W-1:0] addr_p1, addr_d;
  logic [DATA_W-1:0] wdata_p1, wdata_d;
  logic              rw_p1, rw_d;
  logic              wbv_p1, wbv_d;
  logic              wbwe_p1, wbwe_d;
  logic [DATA_W-1:0] wbdata_p1, wbdata_d;
  logic              err_p1, err_d;
  logic              ctr_clr, ctr_en, ctr_expired;

  // An ack cycle never counts toward the timeout, so a coincident ack wins.
  assign ctr_en = (state_p1 == WAIT) && !mem.mem_ack;

  y_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (ctr_clr),
    .en      (ctr_en),
    .expired (ctr_expired)
  );

  always_comb begin
    state_d  = state_p1;
    req_d    = req_p1;
    we_d     = we_p1;
    addr_d   = addr_p1;
    wdata_d  = wdata_p1;
    rw_d     = rw_p1;
    wbv_d    = 1'b0;
    wbwe_d   = 1'b0;
    wbdata_d = wbdata_p1;
    err_d    = 1'b0;
    ctr_clr  = 1'b0;
    unique case (state_p1)
      IDLE: begin
        if (in_valid) begin
          if (!MemRead && !MemWrite) begin
            wbv_d    = 1'b1;
            wbwe_d   = RegWrite;
            wbdata_d = z;
          end else if ((z[1:0] != 2'b00) || (MemRead && MemWrite)) begin
            err_d = 1'b1;
          end else begin
            addr_d  = z;
            wdata_d = rd2;
            we_d    = MemWrite;
            rw_d    = RegWrite;
            req_d   = 1'b1;
            ctr_clr = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem.mem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wbv_d   = 1'b1;
          state_d = IDLE;
          if (we_p1) begin
            wbdata_d = addr_p1;
            wbwe_d   = 1'b0;
          end else begin
            wbdata_d = mem.mem_rdata;
            wbwe_d   = rw_p1;
          end
        end else if (ctr_expired) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage boundary: registered bus request and writeback outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1  <= IDLE;
      req_p1    <= 1'b0;
      we_p1     <= 1'b0;
      addr_p1   <= '0;
      wdata_p1  <= '0;
      rw_p1     <= 1'b0;
      wbv_p1    <= 1'b0;
      wbwe_p1   <= 1'b0;
      wbdata_p1 <= '0;
      err_p1    <= 1'b0;
    end else begin
      state_p1  <= state_d;
      req_p1    <= req_d;
      we_p1     <= we_d;
      addr_p1   <= addr_d;
      wdata_p1  <= wdata_d;
      rw_p1     <= rw_d;
      wbv_p1    <= wbv_d;
      wbwe_p1   <= wbwe_d;
      wbdata_p1 <= wbdata_d;
      err_p1    <= err_d;
    end
  end

  assign stall         = (state_p1 == WAIT);
  assign mem.mem_req   = req_p1;
  assign mem.mem_we    = we_p1;
  assign mem.mem_addr  = addr_p1;
  assign mem.mem_wdata = wdata_p1;
  assign wb_valid      = wbv_p1;
  assign wb_we         = wbwe_p1;
  assign wb_data       = wbdata_p1;
  assign err           = err_p1;

endmodule
